spawn_scheduler: RTL and testbench

SPAWN_SCHEDULER -- requirements
Module: spawn_scheduler

---
 rtl/spawn_scheduler_pkg.sv | 31 +++
 rtl/spawn_fifo.sv | 60 ++++++
 rtl/spawn_scheduler.sv | 150 +++++++++++++++
 tb/tb_spawn_scheduler.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/spawn_scheduler_pkg.sv
// Shared game typedefs and constants for the spawn path (Alien record, level width, scene codes).
// Also holds the default spawn pacing and the scheduler state encoding.
package spawn_scheduler_pkg;

    localparam int LEVEL_SIZE = 6;

    typedef enum logic [1:0] {
        SCENE_TITLE    = 2'd0,
        SCENE_INGAME   = 2'd1,
        SCENE_GAMEOVER = 2'd2
    } scene_t;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] x_pos;
        logic [4:0] speed;
    } Alien;

    localparam int ALIEN_W = $bits(Alien);

    localparam int DEF_BASE_INTERVAL = 50;
    localparam int DEF_MIN_INTERVAL  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/spawn_fifo.sv
// Generic synchronous FIFO, power-of-two depth, with synchronous flush.
// Latency: written entry readable the cycle after push; caller must not push when full unless popping.
module spawn_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk_main,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk_main) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_main or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spawn_scheduler.sv
// Paces alien spawns per level into a small FIFO and hands them to event_core; SPAWN_CAP_EN gates pops on live-object count.
// Latency: tick that hits the interval -> spawn_valid two edges later; output holds until spawn_ack, full FIFO drops and counts.
module spawn_scheduler
    import spawn_scheduler_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int BASE_INTERVAL = DEF_BASE_INTERVAL,
    parameter int MIN_INTERVAL  = DEF_MIN_INTERVAL,
    parameter int MAX_OBJECTS   = 8
) (
    input  logic                          clk_main,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          level_start,
    input  logic [LEVEL_SIZE-1:0]         cur_level,
    input  logic                          tick,
    input  logic                          script_ended,
    input  logic [ALIEN_W-1:0]            candidate,
    input  logic [3:0]                    object_count,
    input  logic                          spawn_ack,
    output logic                          spawn_valid,
    output logic [ALIEN_W-1:0]            spawn_data,
    output logic [$clog2(FIFO_DEPTH):0]   pending,
    output logic [7:0]                    drop_count,
    output logic                          sched_done
);

    localparam logic [7:0] BASE8 = 8'(BASE_INTERVAL);
    localparam logic [7:0] MIN8  = 8'(MIN_INTERVAL);

    sched_state_t        state;
    logic [7:0]          tick_cnt;
    logic [7:0]          level_x2;
    logic [7:0]          interval;
    logic                push_req;
    logic [ALIEN_W-1:0]  push_dat;
    logic                flush;
    logic                enq_hit;
    logic                cap_ok;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic                drop;
    logic [ALIEN_W-1:0]  fifo_rd;

    // Floor check is done before subtracting so high levels cannot wrap the 8-bit interval.
    assign level_x2 = 8'({cur_level, 1'b0});
    always_comb begin
        interval = MIN8;
        if ((BASE8 > level_x2) && ((BASE8 - level_x2) > MIN8)) begin
            interval = BASE8 - level_x2;
        end
    end

`ifdef SPAWN_CAP_EN
    assign cap_ok = (32'(object_count) < MAX_OBJECTS);
`else
    logic unused_cap;
    assign unused_cap = ^{object_count, 32'(MAX_OBJECTS)};
    assign cap_ok     = 1'b1;
`endif

    assign flush     = level_start | ~en;
    assign enq_hit   = (state == RUN) && tick && (tick_cnt >= interval - 8'd1);
    assign fifo_pop  = ~flush & ~fifo_empty & cap_ok & (~spawn_valid | spawn_ack);
    assign fifo_push = ~flush & push_req & (~fifo_full | fifo_pop);
    assign drop      = ~flush & push_req & fifo_full & ~fifo_pop;

    spawn_fifo #(
        .WIDTH (ALIEN_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_main  (clk_main),
        .rst       (rst),
        .flush     (flush),
        .push      (fifo_push),
        .push_data (push_dat),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (pending)
    );

    always_ff @(posedge clk_main or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sched_done <= 1'b0;
        end else if (!en) begin
            state      <= IDLE;
            sched_done <= 1'b0;
        end else if (level_start) begin
            state      <= RUN;
            sched_done <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (script_ended) begin
                        state <= DRAIN;
                    end
                end
                // A staged push still in flight must land before the level counts as finished.
                DRAIN: begin
                    if (fifo_empty && !spawn_valid && !push_req) begin
                        state      <= DONE;
                        sched_done <= 1'b1;
                    end
                end
                default: state <= state;
            endcase
        end
    end

    always_ff @(posedge clk_main or posedge rst) begin
        if (rst) begin
            tick_cnt    <= '0;
            push_req    <= 1'b0;
            push_dat    <= '0;
            spawn_valid <= 1'b0;
            spawn_data  <= '0;
            drop_count  <= '0;
        end else if (flush) begin
            tick_cnt    <= '0;
            push_req    <= 1'b0;
            spawn_valid <= 1'b0;
            if (level_start) begin
                drop_count <= '0;
            end
        end else begin
            push_req <= enq_hit;
            if (enq_hit) begin
                push_dat <= candidate;
            end
            if ((state == RUN) && tick) begin
                tick_cnt <= enq_hit ? 8'd0 : tick_cnt + 8'd1;
            end
            if (fifo_pop) begin
                spawn_valid <= 1'b1;
                spawn_data  <= fifo_rd;
            end else if (spawn_ack) begin
                spawn_valid <= 1'b0;
            end
            if (drop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_spawn_scheduler.sv
// Directed bench for spawn_scheduler: pacing, latency, backpressure/drop, drain to done, disable flush.
module tb_spawn_scheduler;
    import spawn_scheduler_pkg::*;

    logic                  clk_main = 1'b0;
    logic                  rst;
    logic                  en;
    logic                  level_start;
    logic [LEVEL_SIZE-1:0] cur_level;
    logic                  tick;
    logic                  script_ended;
    logic [ALIEN_W-1:0]    candidate;
    logic [3:0]            object_count;
    logic                  spawn_ack;
    logic                  spawn_valid;
    logic [ALIEN_W-1:0]    spawn_data;
    logic [2:0]            pending;
    logic [7:0]            drop_count;
    logic                  sched_done;

    int errors = 0;
    int checks = 0;
    int cyc_n = 0;
    int spawns = 0;
    int first_valid = -1;
    int t_hit = 0;
    logic [ALIEN_W-1:0] first_data = '0;

    always #5 clk_main = ~clk_main;

    spawn_scheduler dut (
        .clk_main     (clk_main),
        .rst          (rst),
        .en           (en),
        .level_start  (level_start),
        .cur_level    (cur_level),
        .tick         (tick),
        .script_ended (script_ended),
        .candidate    (candidate),
        .object_count (object_count),
        .spawn_ack    (spawn_ack),
        .spawn_valid  (spawn_valid),
        .spawn_data   (spawn_data),
        .pending      (pending),
        .drop_count   (drop_count),
        .sched_done   (sched_done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        if (spawn_valid && spawn_ack) spawns++;
        @(posedge clk_main);
        #1;
        cyc_n++;
        if (spawn_valid && first_valid < 0) begin
            first_valid = cyc_n;
            first_data  = spawn_data;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // One tick pulse followed by three quiet cycles; candidate tagged by tick index.
    task automatic do_tick(input int idx);
        candidate = 16'(idx * 13 + 5);
        tick = 1'b1;
        step();
        tick = 1'b0;
        t_hit = cyc_n;
        idle(3);
    endtask

    task automatic start_level(input int lvl);
        cur_level   = 6'(lvl);
        level_start = 1'b1;
        step();
        level_start = 1'b0;
        first_valid = -1;
        spawns      = 0;
    endtask

    task automatic check_interval(input int lvl, input int exp_iv, input string tag);
        spawn_ack = 1'b1;
        start_level(lvl);
        for (int i = 1; i < exp_iv; i++) do_tick(i);
        check_val({tag, "_early"}, 32'(first_valid < 0), 32'd1);
        do_tick(exp_iv);
        check_val({tag, "_lat"}, 32'(first_valid - t_hit), 32'd2);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; level_start = 1'b0; cur_level = '0; tick = 1'b0;
        script_ended = 1'b0; candidate = '0; object_count = '0; spawn_ack = 1'b0;
        #12;
        check_val("rst_valid", 32'(spawn_valid), 0);
        check_val("rst_data", 32'(spawn_data), 0);
        check_val("rst_pending", 32'(pending), 0);
        check_val("rst_drop", 32'(drop_count), 0);
        check_val("rst_done", 32'(sched_done), 0);
        rst = 1'b0;
        en  = 1'b1;
        step();

        // Level 0 pacing: interval 50, ack tied high, 120 ticks.
        spawn_ack = 1'b1;
        start_level(0);
        for (int i = 1; i <= 120; i++) begin
            do_tick(i);
            if (i == 50) check_val("lvl0_lat", 32'(first_valid - t_hit), 32'd2);
        end
        check_val("lvl0_spawns", 32'(spawns), 32'd2);
        check_val("lvl0_data", 32'(first_data), 32'd655);
        check_val("lvl0_pending", 32'(pending), 0);
        check_val("lvl0_done", 32'(sched_done), 0);

        check_interval(5, 40, "iv_l5");
        check_interval(30, 10, "iv_l30");
        check_interval(19, 12, "iv_l19");
        check_interval(63, 10, "iv_l63");

        // Backpressure: ack low, level 20 (interval 10), six enqueues.
        spawn_ack = 1'b0;
        start_level(20);
        for (int i = 1; i <= 60; i++) do_tick(i);
        check_val("bp_pending", 32'(pending), 32'd4);
        check_val("bp_drop", 32'(drop_count), 32'd1);
        check_val("bp_valid", 32'(spawn_valid), 32'd1);
        check_val("bp_data", 32'(spawn_data), 32'd135);
        spawn_ack = 1'b1;
        step();
        spawn_ack = 1'b0;
        check_val("b2b_valid", 32'(spawn_valid), 32'd1);
        check_val("b2b_data", 32'(spawn_data), 32'd265);
        check_val("b2b_pending", 32'(pending), 32'd3);
        start_level(20);
        check_val("ls_pending", 32'(pending), 0);
        check_val("ls_valid", 32'(spawn_valid), 0);
        check_val("ls_drop", 32'(drop_count), 0);

        // Drain: three queued spawns, ack every third cycle, then done.
        for (int i = 1; i <= 30; i++) do_tick(i);
        check_val("dr_pending", 32'(pending), 32'd2);
        script_ended = 1'b1;
        step();
        script_ended = 1'b0;
        for (int k = 0; k < 3; k++) begin
            spawn_ack = 1'b1;
            step();
            spawn_ack = 1'b0;
            idle(2);
            if (k == 0) check_val("dr_mid_done", 32'(sched_done), 0);
        end
        check_val("dr_spawns", 32'(spawns), 32'd3);
        check_val("dr_done", 32'(sched_done), 32'd1);
        for (int i = 1; i <= 15; i++) do_tick(i);
        check_val("done_pending", 32'(pending), 0);
        check_val("done_valid", 32'(spawn_valid), 0);
        check_val("done_hold", 32'(sched_done), 32'd1);

        // Disable mid-run flushes FIFO and output, then nothing enqueues in IDLE.
        start_level(20);
        for (int i = 1; i <= 20; i++) do_tick(i);
        check_val("en_pre_valid", 32'(spawn_valid), 32'd1);
        check_val("en_pre_pending", 32'(pending), 32'd1);
        en = 1'b0;
        step();
        check_val("en0_valid", 32'(spawn_valid), 0);
        check_val("en0_pending", 32'(pending), 0);
        en = 1'b1;
        for (int i = 1; i <= 15; i++) do_tick(i);
        check_val("idle_pending", 32'(pending), 0);
        check_val("idle_valid", 32'(spawn_valid), 0);

        // Live-object cap.
        object_count = 4'd8;
        start_level(20);
        for (int i = 1; i <= 10; i++) do_tick(i);
`ifdef SPAWN_CAP_EN
        check_val("cap_block_valid", 32'(spawn_valid), 0);
        check_val("cap_block_pending", 32'(pending), 32'd1);
        object_count = 4'd7;
        step();
        check_val("cap_release_valid", 32'(spawn_valid), 32'd1);
`else
        check_val("nocap_valid", 32'(spawn_valid), 32'd1);
`endif
        object_count = 4'd0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
